rip_trap_ctrl: RTL and testbench

- Machine-mode trap sequencer and CSR owner for the RIP core.
- Accepts exceptions (illegal instruction, ecall) and mret from the execute stage.
- Drains the pipeline, saves MEPC/MCAUSE and redirects fetch to MTVEC, or to MEPC on mret.
- Services Zicsr reads/writes for MTVEC, MEPC, MCAUSE, CYCLE and the BPTP/BPTN/BPFP/BPFN branch-predictor statistics counters.

---
 rtl/rip_trap_ctrl_pkg.sv | 38 +++
 rtl/rip_bp_stat_counters.sv | 54 +++++
 rtl/rip_trap_ctrl.sv | 152 +++++++++++++++
 tb/tb_rip_trap_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rip_trap_ctrl_pkg.sv
// Shared configuration for the RIP trap controller: CSR map, cause codes,
// trap FSM state/kind types and redirect latencies.
package rip_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_CYCLE  = 12'hC00;
  localparam logic [11:0] CSR_BPTP   = 12'hFC0;
  localparam logic [11:0] CSR_BPTN   = 12'hFC1;
  localparam logic [11:0] CSR_BPFP   = 12'hFC2;
  localparam logic [11:0] CSR_BPFN   = 12'hFC3;

  localparam int CAUSE_ILLEGAL_INST = 2;
  localparam int CAUSE_ECALL        = 11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } trap_state_e;

  typedef enum logic {
    EXC  = 1'b0,
    MRET = 1'b1
  } trap_kind_e;

  // Cycles from the exc_valid/mret_valid cycle to the redirect strobe,
  // assuming flush_done is already high.
  localparam int EXC_REDIRECT_LAT  = 3;
  localparam int MRET_REDIRECT_LAT = 2;

  function automatic logic is_bp_addr(input logic [11:0] addr);
    return addr[11:2] == CSR_BPTP[11:2];
  endfunction

endpackage

// File: rtl/rip_bp_stat_counters.sv
// Branch-predictor outcome counters (TP/TN/FP/FN) with CSR read mux.
// Only built when RIP_BP_STATS_EN is defined.
`ifdef RIP_BP_STATS_EN
module rip_bp_stat_counters
  import rip_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bp_update,
  input  logic            bp_pred_taken,
  input  logic            bp_actual_taken,
  input  logic [11:0]     csr_addr,
  output logic [XLEN-1:0] rdata,
  output logic            hit
);

  logic [XLEN-1:0] r_tp;
  logic [XLEN-1:0] r_tn;
  logic [XLEN-1:0] r_fp;
  logic [XLEN-1:0] r_fn;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tp <= '0;
      r_tn <= '0;
      r_fp <= '0;
      r_fn <= '0;
    end else if (bp_update) begin
      case ({bp_pred_taken, bp_actual_taken})
        2'b11:   r_tp <= r_tp + 1'b1;
        2'b00:   r_tn <= r_tn + 1'b1;
        2'b10:   r_fp <= r_fp + 1'b1;
        default: r_fn <= r_fn + 1'b1;
      endcase
    end
  end

  always_comb begin
    hit   = is_bp_addr(csr_addr);
    rdata = '0;
    if (hit) begin
      case (csr_addr[1:0])
        2'd0:    rdata = r_tp;
        2'd1:    rdata = r_tn;
        2'd2:    rdata = r_fp;
        default: rdata = r_fn;
      endcase
    end
  end

endmodule
`endif

// File: rtl/rip_trap_ctrl.sv
// Machine-mode trap sequencer and CSR owner for the RIP core.
// Optional branch-predictor statistics CSRs under RIP_BP_STATS_EN.
module rip_trap_ctrl
  import rip_trap_ctrl_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            mret_valid,
  output logic            flush_req,
  input  logic            flush_done,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  input  logic            csr_re,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            bp_update,
  input  logic            bp_pred_taken,
  input  logic            bp_actual_taken
);

  trap_state_e     r_state;
  trap_kind_e      r_kind;
  logic [XLEN-1:0] r_cause;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_cycle;

  logic [XLEN-1:0] w_rdata;
  logic            w_mapped;
  logic            w_ro;
  logic            w_csr_wr;

`ifdef RIP_BP_STATS_EN
  logic [XLEN-1:0] w_bp_rdata;
  logic            w_bp_hit;

  rip_bp_stat_counters #(
    .XLEN(XLEN)
  ) u_bp_stats (
    .clk             (clk),
    .rst             (rst),
    .bp_update       (bp_update),
    .bp_pred_taken   (bp_pred_taken),
    .bp_actual_taken (bp_actual_taken),
    .csr_addr        (csr_addr),
    .rdata           (w_bp_rdata),
    .hit             (w_bp_hit)
  );
`else
  logic w_unused_bp;
  assign w_unused_bp = bp_update ^ bp_pred_taken ^ bp_actual_taken;
`endif

  // A faulting instruction never retires, so its CSR write is dropped.
  assign w_csr_wr = csr_we && (r_state == IDLE) && !exc_valid && w_mapped && !w_ro;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_kind   <= EXC;
      r_cause  <= '0;
      r_pc     <= '0;
      r_mtvec  <= MTVEC_RESET;
      r_mepc   <= '0;
      r_mcause <= '0;
      r_cycle  <= '0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      case (r_state)
        IDLE: begin
          if (exc_valid) begin
            r_cause <= exc_cause;
            r_pc    <= exc_pc;
            r_kind  <= EXC;
            r_state <= DRAIN;
          end else if (mret_valid) begin
            r_kind  <= MRET;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (flush_done) r_state <= (r_kind == EXC) ? COMMIT : REDIRECT;
        end
        COMMIT: begin
          r_mepc   <= {r_pc[XLEN-1:2], 2'b00};
          r_mcause <= r_cause;
          r_state  <= REDIRECT;
        end
        REDIRECT: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase

      if (w_csr_wr) begin
        case (csr_addr)
          CSR_MTVEC:  r_mtvec  <= csr_wdata;
          CSR_MEPC:   r_mepc   <= csr_wdata;
          CSR_MCAUSE: r_mcause <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata  = '0;
    w_mapped = 1'b1;
    w_ro     = 1'b0;
    case (csr_addr)
      CSR_MTVEC:  w_rdata = r_mtvec;
      CSR_MEPC:   w_rdata = r_mepc;
      CSR_MCAUSE: w_rdata = r_mcause;
      CSR_CYCLE: begin
        w_rdata = r_cycle;
        w_ro    = 1'b1;
      end
      default: begin
`ifdef RIP_BP_STATS_EN
        if (w_bp_hit) begin
          w_rdata = w_bp_rdata;
          w_ro    = 1'b1;
        end else begin
          w_mapped = 1'b0;
        end
`else
        w_mapped = 1'b0;
`endif
      end
    endcase
  end

  assign csr_rdata   = w_rdata;
  assign csr_illegal = ((csr_re || csr_we) && !w_mapped) || (csr_we && w_ro);

  assign busy           = (r_state != IDLE);
  assign flush_req      = (r_state == DRAIN);
  assign redirect_valid = (r_state == REDIRECT);
  assign redirect_pc    = !redirect_valid ? '0 :
                          (r_kind == EXC) ? {r_mtvec[XLEN-1:2], 2'b00} : r_mepc;

endmodule

// File: tb/tb_rip_trap_ctrl.sv
// Self-checking bench for rip_trap_ctrl; redirect targets go through a
// scoreboard queue, other checks are inline per scenario.
module tb_rip_trap_ctrl;
  import rip_trap_ctrl_pkg::*;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] MTVEC_RST = 32'h0;

  logic            clk;
  logic            rst;
  logic            exc_valid;
  logic [XLEN-1:0] exc_cause;
  logic [XLEN-1:0] exc_pc;
  logic            mret_valid;
  logic            flush_req;
  logic            flush_done;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;
  logic            csr_re;
  logic            csr_we;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            bp_update;
  logic            bp_pred_taken;
  logic            bp_actual_taken;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] mon_exp;
  int              n_checks;
  int              n_fail;
  int              n_redirects;

  rip_trap_ctrl #(.XLEN(XLEN), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk             (clk),
    .rst             (rst),
    .exc_valid       (exc_valid),
    .exc_cause       (exc_cause),
    .exc_pc          (exc_pc),
    .mret_valid      (mret_valid),
    .flush_req       (flush_req),
    .flush_done      (flush_done),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .busy            (busy),
    .csr_re          (csr_re),
    .csr_we          (csr_we),
    .csr_addr        (csr_addr),
    .csr_wdata       (csr_wdata),
    .csr_rdata       (csr_rdata),
    .csr_illegal     (csr_illegal),
    .bp_update       (bp_update),
    .bp_pred_taken   (bp_pred_taken),
    .bp_actual_taken (bp_actual_taken)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Redirect scoreboard
  always @(negedge clk) begin
    if (!rst && redirect_valid) begin
      n_redirects++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL redirect_unexpected: got pc=%h, no redirect expected", redirect_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (redirect_pc !== mon_exp) begin
          n_fail++;
          $display("FAIL redirect_pc: got %h, expected %h", redirect_pc, mon_exp);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [XLEN-1:0] d, output logic ill);
    csr_re   = 1'b1;
    csr_addr = a;
    #1;
    d   = csr_rdata;
    ill = csr_illegal;
    csr_re = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [XLEN-1:0] d);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] d;
    logic            ill;
    logic [11:0]     addrs[3];
    logic [XLEN-1:0] exps[3];
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({flush_req, redirect_valid, busy, csr_illegal} !== 4'b0 || redirect_pc !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got fr=%b rv=%b busy=%b ill=%b pc=%h, expected all 0",
               flush_req, redirect_valid, busy, csr_illegal, redirect_pc);
    end
    rst = 1'b0;
    addrs = '{CSR_MTVEC, CSR_MEPC, CSR_MCAUSE};
    exps  = '{MTVEC_RST, 32'h0, 32'h0};
    for (int i = 0; i < 3; i++) begin
      csr_read(addrs[i], d, ill);
      n_checks++;
      if (d !== exps[i] || ill !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_csr_%h: got %h ill=%b, expected %h ill=0", addrs[i], d, ill, exps[i]);
      end
    end
  endtask

  task automatic test_cycle();
    logic [XLEN-1:0] c0, c1;
    logic            ill;
    tick();
    csr_read(CSR_CYCLE, c0, ill);
    repeat (10) tick();
    csr_read(CSR_CYCLE, c1, ill);
    n_checks++;
    if (c1 - c0 !== 32'd10) begin
      n_fail++;
      $display("FAIL cycle_delta: got %0d, expected 10", c1 - c0);
    end
  endtask

  task automatic test_exc_fast();
    logic [XLEN-1:0] d;
    logic            ill;
    flush_done = 1'b1;
    csr_write(CSR_MTVEC, 32'h100);
    csr_read(CSR_MTVEC, d, ill);
    n_checks++;
    if (d !== 32'h100) begin
      n_fail++;
      $display("FAIL mtvec_write: got %h, expected 00000100", d);
    end
    exc_valid = 1'b1;
    exc_cause = CAUSE_ILLEGAL_INST;
    exc_pc    = 32'h2004;
    exp_q.push_back(32'h100);
    tick();
    exc_valid = 1'b0;
    for (int i = 1; i <= EXC_REDIRECT_LAT; i++) begin
      n_checks++;
      if (redirect_valid !== (i == EXC_REDIRECT_LAT) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL exc_latency_c%0d: got rv=%b busy=%b, expected rv=%b busy=1",
                 i, redirect_valid, busy, (i == EXC_REDIRECT_LAT));
      end
      if (i < EXC_REDIRECT_LAT) tick();
    end
    tick();
    csr_read(CSR_MEPC, d, ill);
    n_checks++;
    if (d !== 32'h2004) begin
      n_fail++;
      $display("FAIL exc_mepc: got %h, expected 00002004", d);
    end
    csr_read(CSR_MCAUSE, d, ill);
    n_checks++;
    if (d !== 32'd2) begin
      n_fail++;
      $display("FAIL exc_mcause: got %h, expected 00000002", d);
    end
  endtask

  task automatic test_ecall_delayed();
    logic [XLEN-1:0] d;
    logic            ill;
    flush_done = 1'b0;
    exc_valid  = 1'b1;
    exc_cause  = CAUSE_ECALL;
    exc_pc     = 32'h3000;
    exp_q.push_back(32'h100);
    tick();
    exc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (flush_req !== 1'b1 || redirect_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ecall_drain_c%0d: got fr=%b rv=%b, expected fr=1 rv=0", i, flush_req, redirect_valid);
      end
      // This MTVEC write lands while busy and must be dropped.
      if (i == 2) csr_write(CSR_MTVEC, 32'h999);
      else tick();
    end
    flush_done = 1'b1;
    for (int i = 0; i < 10 && !redirect_valid; i++) tick();
    n_checks++;
    if (redirect_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ecall_redirect_timeout: got rv=%b, expected 1 within 10 cycles", redirect_valid);
    end
    tick();
    csr_read(CSR_MCAUSE, d, ill);
    n_checks++;
    if (d !== 32'd11) begin
      n_fail++;
      $display("FAIL ecall_mcause: got %h, expected 0000000b", d);
    end
    csr_read(CSR_MTVEC, d, ill);
    n_checks++;
    if (d !== 32'h100) begin
      n_fail++;
      $display("FAIL busy_write_dropped: got mtvec %h, expected 00000100", d);
    end
  endtask

  task automatic test_priority();
    logic [XLEN-1:0] d;
    logic            ill;
    int              start_cnt;
    flush_done = 1'b1;
    start_cnt  = n_redirects;
    exc_valid  = 1'b1;
    mret_valid = 1'b1;
    exc_cause  = CAUSE_ILLEGAL_INST;
    exc_pc     = 32'h4007;
    exp_q.push_back(32'h100);
    tick();
    exc_valid = 1'b0;
    tick();
    tick();
    mret_valid = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (n_redirects - start_cnt !== 1) begin
      n_fail++;
      $display("FAIL priority_one_redirect: got %0d redirects, expected 1", n_redirects - start_cnt);
    end
    csr_read(CSR_MEPC, d, ill);
    n_checks++;
    if (d !== 32'h4004) begin
      n_fail++;
      $display("FAIL priority_mepc_aligned: got %h, expected 00004004", d);
    end
  endtask

  task automatic test_mret();
    flush_done = 1'b1;
    mret_valid = 1'b1;
    exp_q.push_back(32'h4004);
    tick();
    mret_valid = 1'b0;
    n_checks++;
    if (redirect_valid !== 1'b0 || flush_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mret_c1: got rv=%b fr=%b, expected rv=0 fr=1", redirect_valid, flush_req);
    end
    repeat (MRET_REDIRECT_LAT - 1) tick();
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4004) begin
      n_fail++;
      $display("FAIL mret_redirect: got rv=%b pc=%h, expected rv=1 pc=00004004", redirect_valid, redirect_pc);
    end
    tick();
  endtask

  task automatic test_csr_illegal();
    logic [XLEN-1:0] c0, c1, d;
    logic            ill;
    csr_read(CSR_CYCLE, c0, ill);
    tick();
    csr_we = 1'b1; csr_addr = CSR_CYCLE; csr_wdata = '0;
    #1;
    n_checks++;
    if (csr_illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL cycle_write_illegal: got %b, expected 1", csr_illegal);
    end
    tick();
    csr_we = 1'b0;
    csr_read(CSR_CYCLE, c1, ill);
    n_checks++;
    if (c1 !== c0 + 32'd2) begin
      n_fail++;
      $display("FAIL cycle_unchanged: got %h, expected %h", c1, c0 + 32'd2);
    end
    csr_we = 1'b1; csr_addr = 12'h7C0; csr_wdata = 32'h1234;
    #1;
    n_checks++;
    if (csr_illegal !== 1'b1 || csr_rdata !== '0) begin
      n_fail++;
      $display("FAIL unmapped_write: got ill=%b rdata=%h, expected ill=1 rdata=0", csr_illegal, csr_rdata);
    end
    tick();
    csr_we = 1'b0;
    // MEPC write alongside an exception: the write is squashed.
    flush_done = 1'b1;
    csr_we = 1'b1; csr_addr = CSR_MEPC; csr_wdata = 32'h55;
    exc_valid = 1'b1; exc_cause = CAUSE_ILLEGAL_INST; exc_pc = 32'h5000;
    exp_q.push_back(32'h100);
    tick();
    csr_we = 1'b0; exc_valid = 1'b0;
    for (int i = 0; i < 10 && busy; i++) tick();
    csr_read(CSR_MEPC, d, ill);
    n_checks++;
    if (d !== 32'h5000) begin
      n_fail++;
      $display("FAIL mepc_write_with_exc: got %h, expected 00005000", d);
    end
  endtask

  task automatic test_bp_stats();
    logic [XLEN-1:0] d;
    logic            ill;
`ifdef RIP_BP_STATS_EN
    logic [1:0]      pat[6];
    logic [11:0]     addrs[4];
    logic [XLEN-1:0] exps[4];
    pat = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b10, 2'b01};
    for (int i = 0; i < 6; i++) begin
      bp_update = 1'b1;
      {bp_pred_taken, bp_actual_taken} = pat[i];
      tick();
    end
    bp_update = 1'b0;
    addrs = '{CSR_BPTP, CSR_BPTN, CSR_BPFP, CSR_BPFN};
    exps  = '{32'd3, 32'd0, 32'd1, 32'd2};
    for (int i = 0; i < 4; i++) begin
      csr_read(addrs[i], d, ill);
      n_checks++;
      if (d !== exps[i] || ill !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_count_%h: got %0d ill=%b, expected %0d ill=0", addrs[i], d, ill, exps[i]);
      end
    end
`else
    bp_update = 1'b1; bp_pred_taken = 1'b1; bp_actual_taken = 1'b1;
    tick();
    bp_update = 1'b0;
    csr_read(CSR_BPTP, d, ill);
    n_checks++;
    if (d !== '0 || ill !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_unmapped: got rdata=%h ill=%b, expected rdata=0 ill=1", d, ill);
    end
`endif
  endtask

  task automatic test_reset_mid_trap();
    logic [XLEN-1:0] d;
    logic            ill;
    flush_done = 1'b0;
    exc_valid  = 1'b1;
    exc_cause  = CAUSE_ECALL;
    exc_pc     = 32'h6000;
    tick();
    exc_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || flush_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_trap: got busy=%b fr=%b, expected 0 0", busy, flush_req);
    end
    flush_done = 1'b1;
    repeat (4) tick();
    csr_read(CSR_MEPC, d, ill);
    n_checks++;
    if (d !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_mepc: got %h, expected 0", d);
    end
    csr_read(CSR_MCAUSE, d, ill);
    n_checks++;
    if (d !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_mcause: got %h, expected 0", d);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_redirects = 0;
    rst = 1'b1;
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; mret_valid = 1'b0;
    flush_done = 1'b0;
    csr_re = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    bp_update = 1'b0; bp_pred_taken = 1'b0; bp_actual_taken = 1'b0;
    test_reset();
    test_bp_stats();
    test_cycle();
    test_exc_fast();
    test_ecall_delayed();
    test_priority();
    test_mret();
    test_csr_illegal();
    test_reset_mid_trap();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL redirect_missing: %0d expected redirects never seen, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
